// File: rtl/dmem_arbiter_pkg.sv
// Shared types and default sizes for the data-memory arbiter slice.
// Holds the sequencer state encoding and the port identifiers used by the picker and the top.
package dmem_arbiter_pkg;

    localparam int MEM_SPACE = 8;
    localparam int DSIZE     = 16;

    typedef enum logic [1:0] {
        DARB_IDLE  = 2'd0,
        DARB_ISSUE = 2'd1,
        DARB_RESP  = 2'd2
    } darb_state_e;

    typedef enum logic {
        DARB_A = 1'b0,
        DARB_B = 1'b1
    } darb_port_e;

    function automatic darb_port_e other_port(input darb_port_e p);
        return (p == DARB_A) ? DARB_B : DARB_A;
    endfunction

endpackage

// File: rtl/dmem_arbiter_arb_rr2.sv
// Combinational two-way picker: round-robin against the last winner,
// or fixed priority with A winning every tie.
module arb_rr2
    import dmem_arbiter_pkg::*;
(
    input  logic       req_a,
    input  logic       req_b,
    input  darb_port_e last,
    input  logic       prio_mode,
    output logic       grant_valid,
    output darb_port_e grant_id
);

    always_comb begin
        // NOTE: every output gets a default first so no path through the block infers a latch.
        grant_valid = req_a | req_b;
        grant_id    = DARB_A;
        if (req_a && req_b) begin
            grant_id = prio_mode ? DARB_A : other_port(last);
        end else if (req_b) begin
            grant_id = DARB_B;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter and sequencer in front of a single-port synchronous data memory.
// Each access takes one ISSUE cycle then one RESP cycle; RESP may chain straight into the next ISSUE.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int AW        = MEM_SPACE,
    parameter int DW        = DSIZE,
    parameter int PRIO_MODE = 0
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_gnt,
    output logic          a_done,
    output logic [DW-1:0] a_rdata,

    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_gnt,
    output logic          b_done,
    output logic [DW-1:0] b_rdata,

    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata,

    output logic          busy
);

    darb_state_e   state;
    darb_port_e    owner;
    darb_port_e    last_grant;
    logic          lat_we;

    logic          grant_valid;
    darb_port_e    grant_id;
    logic          arb_window;

    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    arb_rr2 u_pick (
        .req_a       (a_req),
        .req_b       (b_req),
        .last        (last_grant),
        .prio_mode   (PRIO_MODE != 0),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    // Requests are only looked at when the sequencer is free to start a new access.
    assign arb_window = (state == DARB_IDLE) || (state == DARB_RESP);

    always_comb begin
        sel_we    = a_we;
        sel_addr  = a_addr;
        sel_wdata = a_wdata;
        if (grant_id == DARB_B) begin
            sel_we    = b_we;
            sel_addr  = b_addr;
            sel_wdata = b_wdata;
        end
    end

    // mem_addr/mem_wdata double as the request latch, so they hold outside ISSUE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= DARB_IDLE;
            owner      <= DARB_A;
            last_grant <= DARB_B;
            lat_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_we     <= 1'b0;
            a_gnt      <= 1'b0;
            b_gnt      <= 1'b0;
            a_done     <= 1'b0;
            b_done     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            a_gnt  <= 1'b0;
            b_gnt  <= 1'b0;
            a_done <= 1'b0;
            b_done <= 1'b0;
            mem_we <= 1'b0;
            unique case (state)
                DARB_ISSUE: begin
                    state  <= DARB_RESP;
                    a_done <= (owner == DARB_A);
                    b_done <= (owner == DARB_B);
                    busy   <= 1'b1;
                end
                DARB_IDLE, DARB_RESP: begin
                    if (arb_window && grant_valid) begin
                        state      <= DARB_ISSUE;
                        owner      <= grant_id;
                        last_grant <= grant_id;
                        lat_we     <= sel_we;
                        mem_addr   <= sel_addr;
                        mem_wdata  <= sel_wdata;
                        mem_we     <= sel_we;
                        a_gnt      <= (grant_id == DARB_A);
                        b_gnt      <= (grant_id == DARB_B);
                        busy       <= 1'b1;
                    end else begin
                        state <= DARB_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= DARB_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Read data comes straight from the memory's output register during RESP.
    assign a_rdata = (a_done && !lat_we) ? mem_rdata : '0;
    assign b_rdata = (b_done && !lat_we) ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: table of single accesses plus hand-written
// sequences for reset, contention, round-robin vs fixed priority and reset mid-access.
module tb_dmem_arbiter;
    localparam int AW = 8;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;

    logic          a_req = 0, a_we = 0;
    logic [AW-1:0] a_addr = '0;
    logic [DW-1:0] a_wdata = '0;
    logic          a_gnt, a_done;
    logic [DW-1:0] a_rdata;
    logic          b_req = 0, b_we = 0;
    logic [AW-1:0] b_addr = '0;
    logic [DW-1:0] b_wdata = '0;
    logic          b_gnt, b_done;
    logic [DW-1:0] b_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    logic          p_a_req = 0, p_b_req = 0;
    logic          p_a_gnt, p_a_done, p_b_gnt, p_b_done, p_mem_we, p_busy;
    logic [DW-1:0] p_a_rdata, p_b_rdata, p_mem_wdata;
    logic [AW-1:0] p_mem_addr;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(AW), .DW(DW), .PRIO_MODE(0)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_done(a_done), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_done(b_done), .b_rdata(b_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    dmem_arbiter #(.AW(AW), .DW(DW), .PRIO_MODE(1)) dut_p (
        .clk(clk), .rst(rst),
        .a_req(p_a_req), .a_we(1'b0), .a_addr(8'd3), .a_wdata(16'h0),
        .a_gnt(p_a_gnt), .a_done(p_a_done), .a_rdata(p_a_rdata),
        .b_req(p_b_req), .b_we(1'b0), .b_addr(8'd4), .b_wdata(16'h0),
        .b_gnt(p_b_gnt), .b_done(p_b_done), .b_rdata(p_b_rdata),
        .mem_addr(p_mem_addr), .mem_wdata(p_mem_wdata), .mem_we(p_mem_we),
        .mem_rdata(16'h0), .busy(p_busy)
    );

    // Single-port synchronous memory, registered read, loaded with addr+0x1000 on the first edge.
    logic [DW-1:0] mem [256];
    bit            mem_loaded = 1'b0;
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'h1000 + 16'(i);
            mem_loaded <= 1'b1;
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        mem_rdata <= mem[mem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Mutual exclusion of pulses, sampled away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            check("a_done/b_done exclusive", 32'(a_done & b_done), 32'd0);
            check("a_gnt/b_gnt exclusive", 32'(a_gnt & b_gnt), 32'd0);
            check("prio a_gnt/b_gnt exclusive", 32'(p_a_gnt & p_b_gnt), 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        string         name;
        logic          port;      // 0 = A, 1 = B
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    task automatic set_req(input logic port, input logic req, input logic we,
                           input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        if (port == 1'b0) begin
            a_req = req; a_we = we; a_addr = addr; a_wdata = wdata;
        end else begin
            b_req = req; b_we = we; b_addr = addr; b_wdata = wdata;
        end
    endtask

    task automatic do_access(input vec_t v);
        set_req(v.port, 1'b1, v.we, v.addr, v.wdata);
        tick();
        check($sformatf("%s gnt{a,b}", v.name), 32'({a_gnt, b_gnt}), v.port ? 32'b01 : 32'b10);
        check($sformatf("%s issue mem_we", v.name), 32'(mem_we), 32'(v.we));
        check($sformatf("%s issue mem_addr", v.name), 32'(mem_addr), 32'(v.addr));
        if (v.we) check($sformatf("%s issue mem_wdata", v.name), 32'(mem_wdata), 32'(v.wdata));
        check($sformatf("%s issue busy", v.name), 32'(busy), 32'd1);
        set_req(v.port, 1'b0, 1'b0, '0, '0);
        tick();
        check($sformatf("%s done{a,b}", v.name), 32'({a_done, b_done}), v.port ? 32'b01 : 32'b10);
        check($sformatf("%s resp mem_we", v.name), 32'(mem_we), 32'd0);
        if (!v.we)
            check($sformatf("%s rdata", v.name), 32'(v.port ? b_rdata : a_rdata), 32'(v.exp_rdata));
        tick();
        check($sformatf("%s idle busy", v.name), 32'(busy), 32'd0);
        check($sformatf("%s idle done{a,b}", v.name), 32'({a_done, b_done}), 32'd0);
        if (v.we) check($sformatf("%s mem content", v.name), 32'(mem[v.addr]), 32'(v.wdata));
    endtask

    vec_t vecs[9];

    initial begin
        vecs[0] = '{"A wr 5",   1'b0, 1'b1, 8'd5,   16'h1234, 16'h0000};
        vecs[1] = '{"B rd 5",   1'b1, 1'b0, 8'd5,   16'h0000, 16'h1234};
        vecs[2] = '{"B wr 200", 1'b1, 1'b1, 8'd200, 16'hBEEF, 16'h0000};
        vecs[3] = '{"A rd 200", 1'b0, 1'b0, 8'd200, 16'h0000, 16'hBEEF};
        vecs[4] = '{"A wr 255", 1'b0, 1'b1, 8'd255, 16'hFFFF, 16'h0000};
        vecs[5] = '{"B rd 255", 1'b1, 1'b0, 8'd255, 16'h0000, 16'hFFFF};
        vecs[6] = '{"A wr 0",   1'b0, 1'b1, 8'd0,   16'h0001, 16'h0000};
        vecs[7] = '{"A rd 0",   1'b0, 1'b0, 8'd0,   16'h0000, 16'h0001};
        vecs[8] = '{"B rd 5b",  1'b1, 1'b0, 8'd5,   16'h0000, 16'h1234};

        // Reset held for two cycles, then idle with no requests.
        tick();
        tick();
        check("reset gnt/done/we/busy", 32'({a_gnt, b_gnt, a_done, b_done, mem_we, busy}), 32'd0);
        check("reset mem_addr", 32'(mem_addr), 32'd0);
        check("reset mem_wdata", 32'(mem_wdata), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("idle %0d mem_we/busy", i), 32'({mem_we, busy}), 32'd0);
        end

        // Simultaneous reads from reset: A wins the first tie, B follows from A's RESP.
        set_req(1'b0, 1'b1, 1'b0, 8'd1, '0);
        set_req(1'b1, 1'b1, 1'b0, 8'd2, '0);
        tick();
        check("tie gnt{a,b} first", 32'({a_gnt, b_gnt}), 32'b10);
        check("tie mem_addr first", 32'(mem_addr), 32'd1);
        set_req(1'b0, 1'b0, 1'b0, '0, '0);
        tick();
        check("tie A done", 32'({a_done, b_done}), 32'b10);
        check("tie A rdata", 32'(a_rdata), 32'h1001);
        check("tie gnt during RESP", 32'({a_gnt, b_gnt}), 32'd0);
        tick();
        check("tie gnt{a,b} second", 32'({a_gnt, b_gnt}), 32'b01);
        check("tie mem_addr second", 32'(mem_addr), 32'd2);
        check("tie mem_we read", 32'(mem_we), 32'd0);
        set_req(1'b1, 1'b0, 1'b0, '0, '0);
        tick();
        check("tie B done", 32'({a_done, b_done}), 32'b01);
        check("tie B rdata", 32'(b_rdata), 32'h1002);
        tick();
        check("tie idle busy", 32'(busy), 32'd0);

        for (int i = 0; i < 9; i++) do_access(vecs[i]);

        // Both ports held: round-robin alternates, fixed priority starves B.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_req(1'b0, 1'b1, 1'b0, 8'd3, '0);
        set_req(1'b1, 1'b1, 1'b0, 8'd4, '0);
        p_a_req = 1'b1;
        p_b_req = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check($sformatf("rr grant %0d", k), 32'({a_gnt, b_gnt}), (k % 2 == 0) ? 32'b10 : 32'b01);
            check($sformatf("prio grant %0d", k), 32'({p_a_gnt, p_b_gnt}), 32'b10);
            if (k == 5) begin
                a_req = 1'b0; b_req = 1'b0; p_a_req = 1'b0; p_b_req = 1'b0;
            end
            tick();
            check($sformatf("rr done %0d", k), 32'({a_done, b_done}), (k % 2 == 0) ? 32'b10 : 32'b01);
            check($sformatf("rr rdata %0d", k), 32'((k % 2 == 0) ? a_rdata : b_rdata),
                  (k % 2 == 0) ? 32'h1003 : 32'h1004);
            check($sformatf("prio done %0d", k), 32'({p_a_done, p_b_done}), 32'b10);
        end
        tick();
        check("rr drained busy", 32'({busy, p_busy}), 32'd0);

        // Reset during ISSUE of an A write abandons it.
        set_req(1'b0, 1'b1, 1'b1, 8'd9, 16'hDEAD);
        tick();
        check("abort issue gnt/we", 32'({a_gnt, mem_we}), 32'b11);
        set_req(1'b0, 1'b0, 1'b0, '0, '0);
        #2 rst = 1'b1;
        #1;
        check("abort async mem_we/busy/gnt", 32'({mem_we, busy, a_gnt}), 32'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("abort no done %0d", i), 32'({a_done, busy}), 32'd0);
        end
        check("abort mem[9] untouched", 32'(mem[9]), 32'h1009);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
